// File: rtl/cla_pipe_addsub_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
// The payload is sized for the widest supported operand (MAX_W); narrower builds use the low bits.
package cla_pkg;

  localparam int MODE_SUB = 0;
  localparam int MODE_SAT = 1;
  localparam int MAX_W    = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef struct packed {
    word_t      a;
    word_t      b;
    word_t      sum;
    logic       carry;
    logic [1:0] mode;
    logic       sign_a;
    logic       ovf;
    logic       zero;
  } stage_t;

  function automatic word_t smax(input int w);
    return (word_t'(1) << (w - 1)) - word_t'(1);
  endfunction

  function automatic word_t smin(input int w);
    return word_t'(1) << (w - 1);
  endfunction

  // Flat sum-of-products carry into position n from p/g bits [n-1:0] and seed c0.
  function automatic logic cla_carry(input word_t p, input word_t g, input int n, input logic c0);
    logic acc;
    logic pp;
    acc = 1'b0;
    pp  = 1'b1;
    for (int i = MAX_W - 1; i >= 0; i--) begin
      if (i < n) begin
        acc = acc | (pp & g[i]);
        pp  = pp & p[i];
      end
    end
    return acc | (pp & c0);
  endfunction

endpackage

// File: rtl/cla_pipe_addsub_if.sv
// Operand/result handshake bundle for cla_pipe_addsub.
// master drives operands and out_ready; slave is the adder side.
interface cla_pipe_addsub_if #(parameter int WIDTH = 16);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
  );
endinterface

// File: rtl/cla_pipe_addsub_group.sv
// GROUP-bit carry-lookahead slice: sum plus group propagate/generate, purely combinational.
// No latency, no handshake.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             p,
  output logic             g
);
  import cla_pkg::*;

  logic [GROUP-1:0] w_p;
  logic [GROUP-1:0] w_g;
  logic [GROUP-1:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  always_comb begin
    w_c = '0;
    for (int i = 0; i < GROUP; i++) begin
      w_c[i] = cla_carry(word_t'(w_p), word_t'(w_g), i, cin);
    end
  end

  assign sum = w_p ^ w_c;
  assign p   = &w_p;
  assign g   = cla_carry(word_t'(w_p), word_t'(w_g), GROUP, 1'b0);

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined CLA add/sub with signed saturation; each stage resolves NG/STAGES groups.
// Latency STAGES cycles, one beat/cycle; a stage advances when empty or its successor advances.
module cla_pipe_addsub
  import cla_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int GROUP  = 4,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  cla_pipe_addsub_if.slave io
);
  localparam int NG = WIDTH / GROUP;
  localparam int K  = NG / STAGES;
  localparam int SW = K * GROUP;

  stage_t            r_pay [STAGES];
  logic [STAGES-1:0] r_v;

  logic [STAGES:0]   w_rdy;
  logic [STAGES-1:0] w_vin;
  logic [WIDTH-1:0]  w_stg_a   [STAGES];
  logic [WIDTH-1:0]  w_stg_b   [STAGES];
  logic [WIDTH-1:0]  w_stg_sum [STAGES];
  logic [1:0]        w_stg_mode[STAGES];
  logic [STAGES-1:0] w_stg_c;
  logic [STAGES-1:0] w_stg_sign;
  logic [STAGES-1:0] w_cout;
  logic [NG-1:0]     w_gp;
  logic [NG-1:0]     w_gg;
  logic [NG-1:0]     w_gc;
  logic [WIDTH-1:0]  w_gsum;
  stage_t            w_nxt [STAGES];

  always_comb begin
    w_rdy         = '0;
    w_vin         = '0;
    w_rdy[STAGES] = io.out_ready;
    for (int s = STAGES - 1; s >= 0; s--) begin
      w_rdy[s] = ~r_v[s] | w_rdy[s+1];
    end
    w_vin[0] = io.in_valid;
    for (int s = 1; s < STAGES; s++) begin
      w_vin[s] = r_v[s-1];
    end
  end

  // Stage 0 takes the bus with B already conditioned for subtract; later stages take the skew registers.
  always_comb begin
    w_stg_a       = '{default: '0};
    w_stg_b       = '{default: '0};
    w_stg_sum     = '{default: '0};
    w_stg_mode    = '{default: '0};
    w_stg_c       = '0;
    w_stg_sign    = '0;
    w_stg_a[0]    = io.in_a;
    w_stg_b[0]    = io.in_mode[MODE_SUB] ? ~io.in_b : io.in_b;
    w_stg_c[0]    = io.in_mode[MODE_SUB];
    w_stg_mode[0] = io.in_mode;
    w_stg_sign[0] = io.in_a[WIDTH-1];
    for (int s = 1; s < STAGES; s++) begin
      w_stg_a[s]    = r_pay[s-1].a[WIDTH-1:0];
      w_stg_b[s]    = r_pay[s-1].b[WIDTH-1:0];
      w_stg_sum[s]  = r_pay[s-1].sum[WIDTH-1:0];
      w_stg_mode[s] = r_pay[s-1].mode;
      w_stg_c[s]    = r_pay[s-1].carry;
      w_stg_sign[s] = r_pay[s-1].sign_a;
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int S = gi / K;
    cla_group #(.GROUP(GROUP)) u_grp (
      .a   (w_stg_a[S][gi*GROUP +: GROUP]),
      .b   (w_stg_b[S][gi*GROUP +: GROUP]),
      .cin (w_gc[gi]),
      .sum (w_gsum[gi*GROUP +: GROUP]),
      .p   (w_gp[gi]),
      .g   (w_gg[gi])
    );
  end

  always_comb begin
    w_gc   = '0;
    w_cout = '0;
    for (int s = 0; s < STAGES; s++) begin
      for (int j = 0; j < K; j++) begin
        w_gc[s*K + j] = cla_carry(word_t'(w_gp >> (s*K)), word_t'(w_gg >> (s*K)), j, w_stg_c[s]);
      end
      w_cout[s] = cla_carry(word_t'(w_gp >> (s*K)), word_t'(w_gg >> (s*K)), K, w_stg_c[s]);
    end
  end

  always_comb begin
    logic [WIDTH-1:0] nsum;
    logic [WIDTH-1:0] fsum;
    logic             cmsb;
    logic             ovf;
    nsum  = '0;
    fsum  = '0;
    cmsb  = 1'b0;
    ovf   = 1'b0;
    w_nxt = '{default: '0};
    for (int s = 0; s < STAGES; s++) begin
      nsum              = w_stg_sum[s];
      nsum[s*SW +: SW]  = w_gsum[s*SW +: SW];
      w_nxt[s].a        = word_t'(w_stg_a[s]);
      w_nxt[s].b        = word_t'(w_stg_b[s]);
      w_nxt[s].sum      = word_t'(nsum);
      w_nxt[s].carry    = w_cout[s];
      w_nxt[s].mode     = w_stg_mode[s];
      w_nxt[s].sign_a   = w_stg_sign[s];
      if (s == STAGES - 1) begin
        // Carry into the MSB falls out of sum ^ a ^ b' at that bit.
        cmsb = nsum[WIDTH-1] ^ w_stg_a[s][WIDTH-1] ^ w_stg_b[s][WIDTH-1];
        ovf  = cmsb ^ w_cout[s];
        fsum = nsum;
        if (w_stg_mode[s][MODE_SAT] && ovf) begin
          fsum = w_stg_sign[s] ? WIDTH'(smin(WIDTH)) : WIDTH'(smax(WIDTH));
        end
        w_nxt[s].sum  = word_t'(fsum);
        w_nxt[s].ovf  = ovf;
        w_nxt[s].zero = (fsum == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int s = 0; s < STAGES; s++) begin
        r_pay[s] <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (w_rdy[s]) begin
          r_v[s]   <= w_vin[s];
          r_pay[s] <= w_nxt[s];
        end
      end
    end
  end

  assign io.in_ready  = w_rdy[0];
  assign io.out_valid = r_v[STAGES-1];
  assign io.out_sum   = r_pay[STAGES-1].sum[WIDTH-1:0];
  assign io.out_cout  = r_pay[STAGES-1].carry;
  assign io.out_ovf   = r_pay[STAGES-1].ovf;
  assign io.out_zero  = r_pay[STAGES-1].zero;

endmodule
